// File: rtl/stack_mem_pkg.sv
// rtl/stack_mem_pkg.sv - shared request op and response error encodings for stack_data_mem
package stack_mem_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ERR_OK        = 3'd0,
    ERR_MISALIGN  = 3'd1,
    ERR_RANGE     = 3'd2,
    ERR_OVERFLOW  = 3'd3,
    ERR_UNDERFLOW = 3'd4,
    ERR_ILLEGAL   = 3'd5
  } err_e;

endpackage

// File: rtl/byte_ram.sv
// rtl/byte_ram.sv - word-addressed RAM built from NB byte lanes, per-lane write enable, registered read
module byte_ram #(
  parameter int NB    = 4,
  parameter int WAW   = 8
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [NB-1:0]   i_be,
  input  logic [WAW-1:0]  i_waddr,
  input  logic [8*NB-1:0] i_wdata,
  input  logic            i_re,
  input  logic [WAW-1:0]  i_raddr,
  output logic [8*NB-1:0] o_rdata
);

  localparam int DEPTH = 2 ** WAW;

  for (genvar g = 0; g < NB; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_byte;

    always_ff @(posedge clk) begin
      if (i_we && i_be[g]) r_mem[i_waddr] <= i_wdata[8*g +: 8];
      if (i_re)            r_byte         <= r_mem[i_raddr];
    end

    assign o_rdata[8*g +: 8] = r_byte;
  end

endmodule

// File: rtl/stack_data_mem.sv
// rtl/stack_data_mem.sv - byte-addressed data memory with a downward-growing hardware stack
module stack_data_mem
  import stack_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int STACK_LIMIT = 768
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [2:0]          rsp_err,
  output logic [ADDR_W:0]     sp,
  output logic                err_sticky
);

  localparam int NB  = DATA_W / 8;
  localparam int LSB = $clog2(NB);
  localparam int WAW = ADDR_W - LSB;
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] NB_SP     = (ADDR_W+1)'(NB);
  localparam logic [ADDR_W:0] PUSH_MIN  = (ADDR_W+1)'(STACK_LIMIT + NB);

  logic              r_rsp_valid, r_rd_ok, r_sticky;
  err_e              r_err;
  logic [ADDR_W:0]   r_sp;

  logic              w_acc, w_resp, w_rd_en, w_rd_ok, w_we;
  err_e              w_err;
  logic [NB-1:0]     w_wbe;
  logic [WAW-1:0]    w_waddr, w_raddr;
  logic [ADDR_W:0]   w_sp_nxt;
  logic [DATA_W-1:0] w_rdata;
  logic              w_misalign, w_range;

  assign w_acc      = req_valid && req_ready;
  assign w_misalign = req_addr[LSB-1:0] != '0;
  assign w_range    = ({1'b0, req_addr} + NB_SP) > MEM_BYTES;

  always_comb begin
    w_resp   = 1'b0;
    w_err    = ERR_OK;
    w_rd_en  = 1'b0;
    w_rd_ok  = 1'b0;
    w_we     = 1'b0;
    w_wbe    = '0;
    w_waddr  = req_addr[ADDR_W-1:LSB];
    w_raddr  = req_addr[ADDR_W-1:LSB];
    w_sp_nxt = r_sp;
    if (w_acc) begin
      case (req_op)
        OP_NOP: ;
        OP_LOAD, OP_STORE: begin
          w_resp = 1'b1;
          if (w_misalign)                w_err = ERR_MISALIGN;
          else if (w_range)              w_err = ERR_RANGE;
          else if (req_op == OP_LOAD) begin
            w_rd_en = 1'b1;
            w_rd_ok = 1'b1;
          end else begin
            w_we  = 1'b1;
            w_wbe = req_be;
          end
        end
        OP_PUSH: begin
          w_resp = 1'b1;
          // Comparing sp against LIMIT+NB avoids an underflowing subtraction near 0.
          if (r_sp < PUSH_MIN) w_err = ERR_OVERFLOW;
          else begin
            w_sp_nxt = r_sp - NB_SP;
            w_we     = 1'b1;
            w_wbe    = '1;
            w_waddr  = w_sp_nxt[ADDR_W-1:LSB];
          end
        end
        OP_POP: begin
          w_resp = 1'b1;
          if (r_sp == MEM_BYTES) w_err = ERR_UNDERFLOW;
          else begin
            w_rd_en  = 1'b1;
            w_rd_ok  = 1'b1;
            w_raddr  = r_sp[ADDR_W-1:LSB];
            w_sp_nxt = r_sp + NB_SP;
          end
        end
        default: begin
          w_resp = 1'b1;
          w_err  = ERR_ILLEGAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp        <= MEM_BYTES;
      r_rsp_valid <= 1'b0;
      r_err       <= ERR_OK;
      r_rd_ok     <= 1'b0;
      r_sticky    <= 1'b0;
    end else begin
      r_sp        <= w_sp_nxt;
      r_rsp_valid <= w_resp;
      r_err       <= w_err;
      r_rd_ok     <= w_rd_ok;
      if (w_resp && w_err != ERR_OK) r_sticky <= 1'b1;
    end
  end

  byte_ram #(
    .NB  (NB),
    .WAW (WAW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (w_wbe),
    .i_waddr (w_waddr),
    .i_wdata (req_wdata),
    .i_re    (w_rd_en),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // RAM output is only meaningful for a successful LOAD/POP; everything else reads as zero.
  assign rsp_data   = r_rd_ok ? w_rdata : '0;
  assign req_ready  = ~rst;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_err    = r_err;
  assign sp         = r_sp;
  assign err_sticky = r_sticky;

endmodule

// File: doc/stack_data_mem.md
STACK_DATA_MEM -- requirements
Module: stack_data_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning byte-address width; memory holds 2**ADDR_W bytes.
REQ-002 SHALL have parameter DATA_W, default 32, meaning word width; a multiple of 8, so NB = DATA_W/8 bytes per word.
REQ-003 SHALL have parameter STACK_LIMIT, default 768, meaning lowest byte address the stack may occupy; a multiple of NB.
REQ-004 SHALL have ports: clk input 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst input 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid input 1, request present.
REQ-007 SHALL have port req_ready output 1, request accepted when high together with req_valid.
REQ-008 SHALL have port req_op input 3, encoding 0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP; other values are illegal.
REQ-009 SHALL have port req_addr input ADDR_W, byte address for LOAD/STORE; ignored for PUSH/POP.
REQ-010 SHALL have port req_wdata input DATA_W, write data for STORE/PUSH.
REQ-011 SHALL have port req_be input NB, byte enables for STORE; PUSH always writes all bytes.
REQ-012 SHALL have port rsp_valid output 1, one-cycle pulse marking rsp_data/rsp_err.
REQ-013 SHALL have port rsp_data output DATA_W, LOAD/POP result, little-endian (byte at lowest address in bits 7:0).
REQ-014 SHALL have port rsp_err output 3, 0 OK, 1 misaligned, 2 out-of-range, 3 overflow, 4 underflow, 5 illegal op.
REQ-015 SHALL have port sp output ADDR_W+1, current stack pointer in bytes.
REQ-016 SHALL have port err_sticky output 1, set by any nonzero rsp_err, cleared only by reset.

Function
REQ-017 SHALL accept one request per cycle; req_ready is 1 whenever rst is low.
REQ-018 SHALL give every accepted non-NOP request exactly one response: rsp_valid high in the cycle after acceptance (latency 1); NOP gives no response.
REQ-019 SHALL check LOAD/STORE in this priority: addr not a multiple of NB gives code 1; addr+NB > 2**ADDR_W gives code 2; memory is untouched on error.
REQ-020 SHALL, on STORE, write only bytes whose req_be bit is 1; rsp_data is 0 for STORE.
REQ-021 SHALL, on PUSH with sp-NB < STACK_LIMIT, respond with code 3, leaving sp and memory unchanged.
REQ-022 SHALL otherwise, on PUSH, set sp := sp-NB and write req_wdata at the new sp in the same edge.
REQ-023 SHALL, on POP with sp == 2**ADDR_W (empty), respond with code 4 and rsp_data 0, leaving sp unchanged.
REQ-024 SHALL otherwise, on POP, return the word at sp and set sp := sp+NB.
REQ-025 SHALL return the new data when a LOAD/POP follows a STORE/PUSH to the same word in the next cycle (no stale read).
REQ-026 SHALL treat LOAD/STORE into the stack region as legal; no protection between data and stack.
REQ-027 SHALL hold rsp_data at 0 whenever rsp_valid is 0 or rsp_err is nonzero.

Reset
REQ-028 SHALL, while rst is high, force sp = 2**ADDR_W, rsp_valid = 0, rsp_data = 0, rsp_err = 0, err_sticky = 0 and req_ready = 0.
REQ-029 SHALL discard a request in flight when rst asserts: no response pulse after release; memory contents need not be cleared.

Structure
REQ-030 SHALL take the op and error encodings from shared package stack_mem_pkg, for use by the decoder and bench.
REQ-031 SHALL place storage in one sub-module byte_ram (byte-wide, NB write lanes, synchronous read); checking, sp and response logic stay in stack_data_mem.

Verification
REQ-032 SHALL cover: STORE addr 8, data 0xDEADBEEF, be 0xF, then LOAD 8 -> next-cycle rsp_data 0xDEADBEEF, err 0.
REQ-033 SHALL cover: STORE addr 8, data 0x11223344, be 0x2, over 0xDEADBEEF -> LOAD 8 returns 0xDEAD33EF.
REQ-034 SHALL cover: PUSH 0xA, PUSH 0xB, POP, POP -> responses 0xB then 0xA; sp 1020, 1016, 1020, 1024.
REQ-035 SHALL cover: POP after reset -> err 4, sp 1024; 64 PUSHes fill 1020..768, 65th -> err 3, sp 768, err_sticky 1.
REQ-036 SHALL cover: LOAD addr 6 -> err 1; LOAD addr 1022 -> err 1; req_op 7 -> err 5, all with rsp_data 0.
REQ-037 SHALL cover: rst asserted while a PUSH is being accepted -> no rsp_valid; after release sp 1024.
